// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Holds the FSM state and arbitration pick encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } arb_state_e;

    typedef enum logic [1:0] {
        PICK_NONE,
        PICK_I,
        PICK_D
    } arb_pick_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational port selection: data port first,
// unless fetch has waited too long.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic      en_i,
    input  logic      if_req_i,
    input  logic      d_req_i,
    input  logic      starve_i,
    output arb_pick_e pick_o
);

    always_comb begin
        pick_o = PICK_NONE;
        if (en_i) begin
            if (d_req_i && !(if_req_i && starve_i)) begin
                pick_o = PICK_D;
            end else if (if_req_i) begin
                pick_o = PICK_I;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports,
// one transaction outstanding, with a fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    arb_pick_e     pick;
    logic          starve;
    logic          arb_en;

    assign starve = (cnt_q == SW'(STARVE_MAX));
    // Gating with reset keeps every output quiet while reset is held.
    assign arb_en = (state_q == IDLE) && reset_ni;

    arb_pick u_pick (
        .en_i     (arb_en),
        .if_req_i (if_req_i),
        .d_req_i  (d_req_i),
        .starve_i (starve),
        .pick_o   (pick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (mem_gnt_i && pick == PICK_D) begin
                    state_d = WAIT_D;
                    we_d    = d_we_i;
                    if (!if_req_i) begin
                        cnt_d = '0;
                    end else if (!starve) begin
                        cnt_d = cnt_q + SW'(1);
                    end
                end else if (mem_gnt_i && pick == PICK_I) begin
                    state_d = WAIT_I;
                    cnt_d   = '0;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

    assign mem_req_o   = (pick != PICK_NONE);
    assign mem_we_o    = (pick == PICK_D) && d_we_i;
    assign mem_addr_o  = (pick == PICK_D) ? d_addr_i :
                         (pick == PICK_I) ? if_addr_i : '0;
    assign mem_wdata_o = (pick == PICK_D) ? d_wdata_i : '0;

    assign if_gnt_o = mem_gnt_i && (pick == PICK_I);
    assign d_gnt_o  = mem_gnt_i && (pick == PICK_D);

    assign if_rvalid_o = (state_q == WAIT_I) && mem_rvalid_i;
    assign d_rvalid_o  = (state_q == WAIT_D) && mem_rvalid_i;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change on the falling edge, outputs are checked 1ns later.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .STARVE_MAX (4),
        .AW         (32),
        .DW         (32)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk_i);
    endtask

    task automatic quiet;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        d_addr_i     = '0;
        d_wdata_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    function automatic logic [31:0] all_out;
        return {18'd0, if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o,
                mem_req_o, mem_we_o, |if_rdata_o, |d_rdata_o,
                |mem_addr_o, |mem_wdata_o, 4'd0};
    endfunction

    initial begin
        quiet();
        reset_ni = 1'b0;
        #1;
        chk("reset_outs", all_out(), 32'd0);
        step();
        step();
        reset_ni = 1'b1;

        // IF only, response two cycles after grant
        step();
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        mem_gnt_i = 1'b1;
        #1;
        chk("t2_if_gnt", {31'd0, if_gnt_o}, 32'd1);
        chk("t2_d_gnt", {31'd0, d_gnt_o}, 32'd0);
        chk("t2_addr", mem_addr_o, 32'h100);
        chk("t2_we", {31'd0, mem_we_o}, 32'd0);
        step();
        if_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        #1;
        chk("t2_wait_req", {31'd0, mem_req_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEADBEEF;
        #1;
        chk("t2_if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
        chk("t2_if_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("t2_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
        step();
        quiet();

        // Contention: D store beats IF
        step();
        if_req_i  = 1'b1;
        if_addr_i = 32'h300;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h200;
        d_wdata_i = 32'h55;
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_we", {31'd0, mem_we_o}, 32'd1);
        chk("t3_d_gnt", {31'd0, d_gnt_o}, 32'd1);
        chk("t3_if_gnt", {31'd0, if_gnt_o}, 32'd0);
        chk("t3_addr", mem_addr_o, 32'h200);
        chk("t3_wdata", mem_wdata_o, 32'h55);
        step();
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        mem_gnt_i = 1'b0;
        #1;
        chk("t3_wait_if_gnt", {31'd0, if_gnt_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1234;
        #1;
        chk("t3_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
        chk("t3_d_rdata", d_rdata_o, 32'd0);
        chk("t3_if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        #1;
        chk("t3_if_gnt_next", {31'd0, if_gnt_o}, 32'd1);
        chk("t3_if_addr", mem_addr_o, 32'h300);
        step();
        quiet();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA5A5;
        #1;
        chk("t3_if_rvalid_end", {31'd0, if_rvalid_o}, 32'd1);
        step();
        quiet();

        // Starvation: both held, expect D,D,D,D,IF,D
        step();
        if_req_i  = 1'b1;
        if_addr_i = 32'h500;
        d_req_i   = 1'b1;
        d_addr_i  = 32'h600;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_g;
            exp_g = (i == 4) ? 32'd2 : 32'd1;
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            #1;
            chk($sformatf("t4_gnt%0d", i),
                {30'd0, if_gnt_o, d_gnt_o}, exp_g);
            step();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h40 + i;
            #1;
            chk($sformatf("t4_rv%0d", i),
                {30'd0, if_rvalid_o, d_rvalid_o}, exp_g);
            step();
        end
        quiet();

        // Back-pressure: three refused cycles then one grant
        step();
        d_req_i  = 1'b1;
        d_addr_i = 32'h400;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t5_req%0d", i), {31'd0, mem_req_o}, 32'd1);
            chk($sformatf("t5_addr%0d", i), mem_addr_o, 32'h400);
            chk($sformatf("t5_gnt%0d", i),
                {30'd0, if_gnt_o, d_gnt_o}, 32'd0);
            step();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk("t5_gnt4", {31'd0, d_gnt_o}, 32'd1);
        step();
        #1;
        chk("t5_single_req", {31'd0, mem_req_o}, 32'd0);
        chk("t5_single_gnt", {31'd0, d_gnt_o}, 32'd0);
        step();
        quiet();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE;
        #1;
        chk("t5_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
        chk("t5_d_rdata", d_rdata_o, 32'hCAFE);
        step();
        quiet();

        // Spurious response while idle
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD;
        #1;
        chk("t6_rvalids", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        if_req_i     = 1'b1;
        if_addr_i    = 32'h700;
        mem_gnt_i    = 1'b1;
        #1;
        chk("t6_still_idle", {31'd0, if_gnt_o}, 32'd1);
        step();
        quiet();
        mem_rvalid_i = 1'b1;
        #1;
        chk("t6_if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
        step();
        quiet();

        // Reset in the middle of a data load
        step();
        d_req_i   = 1'b1;
        d_addr_i  = 32'h800;
        mem_gnt_i = 1'b1;
        #1;
        chk("t1_d_gnt", {31'd0, d_gnt_o}, 32'd1);
        step();
        quiet();
        reset_ni     = 1'b0;
        if_req_i     = 1'b1;
        if_addr_i    = 32'h900;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        chk("t1_rst_outs", all_out(), 32'd0);
        step();
        quiet();
        reset_ni = 1'b1;
        step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        chk("t1_dropped", {30'd0, if_rvalid_o, d_rvalid_o}, 32'd0);
        step();
        quiet();
        if_req_i  = 1'b1;
        if_addr_i = 32'h900;
        mem_gnt_i = 1'b1;
        #1;
        chk("t1_idle_gnt", {31'd0, if_gnt_o}, 32'd1);
        step();
        quiet();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
